// File: rtl/seg_frame_shifter.sv
// Parallel-to-serial frame shifter for the seven-segment / LED shift-register chain.
// A rising edge on start snapshots data, streams it MSB-first on sout/s_clk, then pulses pen.
module seg_frame_shifter #(
  parameter int DATA_BITS       = 64,
  parameter int DATA_COUNT_BITS = 6
) (
  input  logic                 clk,
  input  logic                 clrn,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] data,
  output logic                 s_clk,
  output logic                 s_clrn,
  output logic                 sout,
  output logic                 pen,
  output logic                 busy
);

  // state    | meaning
  // IDLE     | waiting for a rising edge on start
  // SHIFT_LO | s_clk low, current bit presented on sout
  // SHIFT_HI | s_clk high, external chain samples sout
  // LATCH    | one-cycle pen strobe, frame complete
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_LO = 2'd1,
    SHIFT_HI = 2'd2,
    LATCH    = 2'd3
  } state_t;

  localparam logic [DATA_COUNT_BITS-1:0] CNT_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);

  state_t                     state;
  state_t                     state_nxt;
  logic                       start_d;
  logic                       start_edge;
  logic [DATA_BITS-1:0]       shreg;
  logic [DATA_BITS-1:0]       shreg_nxt;
  logic [DATA_COUNT_BITS-1:0] cnt;
  logic [DATA_COUNT_BITS-1:0] cnt_nxt;

  assign start_edge = start & ~start_d;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state   <= IDLE;
      start_d <= 1'b0;
      shreg   <= '0;
      cnt     <= '0;
      s_clrn  <= 1'b0;
    end else begin
      state   <= state_nxt;
      start_d <= start;
      shreg   <= shreg_nxt;
      cnt     <= cnt_nxt;
      s_clrn  <= 1'b1;
    end
  end

  // Edges seen outside IDLE are dropped; start_d still follows start so a held level never retriggers.
  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (start_edge) begin
          shreg_nxt = data;
          cnt_nxt   = '0;
          state_nxt = SHIFT_LO;
        end
      end
      SHIFT_LO: state_nxt = SHIFT_HI;
      SHIFT_HI: begin
        if (cnt == CNT_LAST) begin
          state_nxt = LATCH;
        end else begin
          shreg_nxt = {shreg[DATA_BITS-2:0], 1'b0};
          cnt_nxt   = cnt + DATA_COUNT_BITS'(1);
          state_nxt = SHIFT_LO;
        end
      end
      LATCH:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign s_clk = (state == SHIFT_HI);
  assign sout  = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg[DATA_BITS-1];
  assign pen   = (state == LATCH);
  assign busy  = (state != IDLE);

endmodule

// File: tb/tb_seg_frame_shifter.sv
// Bench for seg_frame_shifter: 64-bit and 16-bit instances checked every cycle
// against a frame-position model, plus literal per-frame expectations.
module tb_seg_frame_shifter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        start;
  logic [63:0] data;
  logic        start16;
  logic [15:0] data16;

  logic s_clk64, s_clrn64, sout64, pen64, busy64;
  logic s_clk16, s_clrn16, sout16, pen16, busy16;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg_frame_shifter #(.DATA_BITS(64), .DATA_COUNT_BITS(6)) dut64 (
    .clk(clk), .clrn(clrn), .start(start), .data(data),
    .s_clk(s_clk64), .s_clrn(s_clrn64), .sout(sout64), .pen(pen64), .busy(busy64)
  );

  seg_frame_shifter #(.DATA_BITS(16), .DATA_COUNT_BITS(4)) dut16 (
    .clk(clk), .clrn(clrn), .start(start16), .data(data16),
    .s_clk(s_clk16), .s_clrn(s_clrn16), .sout(sout16), .pen(pen16), .busy(busy16)
  );

  logic        a_sclk  [2];
  logic        a_sout  [2];
  logic        a_pen   [2];
  logic        a_busy  [2];
  logic        a_sclrn [2];
  logic        st      [2];
  logic [63:0] dt      [2];

  assign a_sclk[0]  = s_clk64;  assign a_sclk[1]  = s_clk16;
  assign a_sout[0]  = sout64;   assign a_sout[1]  = sout16;
  assign a_pen[0]   = pen64;    assign a_pen[1]   = pen16;
  assign a_busy[0]  = busy64;   assign a_busy[1]  = busy16;
  assign a_sclrn[0] = s_clrn64; assign a_sclrn[1] = s_clrn16;
  assign st[0]      = start;    assign st[1]      = start16;
  assign dt[0]      = data;     assign dt[1]      = {48'd0, data16};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int nb(input int i);
    return (i == 0) ? 64 : 16;
  endfunction

  // Model: pos = clocks since the capture edge (-1 when idle). Frame position p covers bit p/2,
  // odd p is the shift-clock-high half, p == 2N is the latch strobe.
  int          pos  [2] = '{-1, -1};
  logic        prev [2] = '{1'b0, 1'b0};
  logic [63:0] word [2] = '{64'd0, 64'd0};
  logic        exp_sclrn = 1'b0;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < 2; i++) begin
        pos[i]  <= -1;
        prev[i] <= 1'b0;
      end
      exp_sclrn <= 1'b0;
    end else begin
      exp_sclrn <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        prev[i] <= st[i];
        if (pos[i] < 0) begin
          if (st[i] && !prev[i]) begin
            pos[i]  <= 0;
            word[i] <= dt[i];
          end
        end else if (pos[i] == 2 * nb(i)) begin
          pos[i] <= -1;
        end else begin
          pos[i] <= pos[i] + 1;
        end
      end
    end
  end

  function automatic logic [3:0] exp_of(input int p, input logic [63:0] w, input int n);
    if (p < 0) return 4'b0000;
    if (p == 2 * n) return 4'b0011;
    return {p[0], w[n - 1 - p / 2], 1'b0, 1'b1};
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk((i == 0) ? "outs64" : "outs16",
          64'({a_sclk[i], a_sout[i], a_pen[i], a_busy[i]}),
          64'(exp_of(pos[i], word[i], nb(i))));
      chk((i == 0) ? "s_clrn64" : "s_clrn16", 64'(a_sclrn[i]), 64'(exp_sclrn));
    end
  end

  // Per-frame observation: bits sampled at s_clk rises, cycle index of pen, busy length.
  int          m_cyc      [2] = '{0, 0};
  int          m_rises    [2] = '{0, 0};
  int          m_pen_cyc  [2] = '{0, 0};
  int          m_busy_cyc [2] = '{0, 0};
  int          m_frames   [2] = '{0, 0};
  logic [63:0] m_bits     [2] = '{64'd0, 64'd0};
  logic        busy_q     [2] = '{1'b0, 1'b0};
  logic        sclk_q     [2] = '{1'b0, 1'b0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      busy_q[i] <= a_busy[i];
      sclk_q[i] <= a_sclk[i];
      if (a_busy[i] && !busy_q[i]) begin
        m_cyc[i]      <= 1;
        m_rises[i]    <= 0;
        m_bits[i]     <= 64'd0;
        m_pen_cyc[i]  <= 0;
        m_busy_cyc[i] <= 1;
        m_frames[i]   <= m_frames[i] + 1;
      end else begin
        if (m_cyc[i] != 0) m_cyc[i] <= m_cyc[i] + 1;
        if (a_busy[i]) m_busy_cyc[i] <= m_busy_cyc[i] + 1;
        if (a_sclk[i] && !sclk_q[i]) begin
          m_bits[i]  <= {m_bits[i][62:0], a_sout[i]};
          m_rises[i] <= m_rises[i] + 1;
        end
        if (a_pen[i]) m_pen_cyc[i] <= m_cyc[i] + 1;
      end
    end
  end

  int f0;

  initial begin
    clrn    = 1'b0;
    start   = 1'b1;
    data    = 64'hA5F0_0000_0000_0001;
    start16 = 1'b0;
    data16  = 16'h8001;

    // reset held with start high, then released with start still high
    repeat (3) @(negedge clk);
    #1 chk("reset_outs64", 64'({s_clk64, sout64, pen64, busy64, s_clrn64}), 64'd0);
    chk("reset_outs16", 64'({s_clk16, sout16, pen16, busy16, s_clrn16}), 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    #1 chk("s_clrn_release", 64'(s_clrn64), 64'd1);
    chk("held_start_frame", 64'(busy64), 64'd1);
    chk("frames_after_release", 64'(m_frames[0]), 64'd1);
    f0 = m_frames[0];
    repeat (300) @(negedge clk);
    #1 chk("w64_bits", m_bits[0], 64'hA5F0_0000_0000_0001);
    chk("w64_rises", 64'(m_rises[0]), 64'd64);
    chk("w64_pen_cycle", 64'(m_pen_cyc[0]), 64'd129);
    chk("w64_busy_cycles", 64'(m_busy_cyc[0]), 64'd129);
    chk("held_start_no_retrigger", 64'(m_frames[0] - f0), 64'd0);
    start = 1'b0;

    // 16-bit frame
    @(negedge clk) start16 = 1'b1;
    @(negedge clk) start16 = 1'b0;
    repeat (40) @(negedge clk);
    #1 chk("w16_bits", m_bits[1], 64'h8001);
    chk("w16_rises", 64'(m_rises[1]), 64'd16);
    chk("w16_pen_cycle", 64'(m_pen_cyc[1]), 64'd33);
    chk("w16_busy_cycles", 64'(m_busy_cyc[1]), 64'd33);

    // data changed mid-frame must not leak into the frame
    data = 64'd0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (9) @(negedge clk);
    data = '1;
    repeat (140) @(negedge clk);
    #1 chk("data_change_bits", m_bits[0], 64'd0);
    chk("data_change_rises", 64'(m_rises[0]), 64'd64);

    // start pulses during the frame, including the latch cycle
    data = 64'h0123_4567_89AB_CDEF;
    f0 = m_frames[0];
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 135; c++) begin
      @(negedge clk);
      start = (c == 5) || (c == 60) || (c == 129);
      if (c == 129) begin
        #1 chk("latch_pen", 64'(pen64), 64'd1);
        chk("latch_busy", 64'(busy64), 64'd1);
      end
      if (c == 130) begin
        #1 chk("busy_fall_130", 64'(busy64), 64'd0);
      end
    end
    repeat (10) @(negedge clk);
    #1 chk("ignored_starts_frames", 64'(m_frames[0] - f0), 64'd1);
    chk("ignored_starts_bits", m_bits[0], 64'h0123_4567_89AB_CDEF);
    start = 1'b0;

    // asynchronous reset mid-frame, then a clean frame
    data = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_reset_busy", 64'(busy64), 64'd1);
    clrn = 1'b0;
    #1 chk("midframe_reset_outs", 64'({s_clk64, sout64, pen64, busy64, s_clrn64}), 64'd0);
    @(negedge clk) clrn = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk("post_reset_idle", 64'(busy64), 64'd0);
    chk("post_reset_s_clrn", 64'(s_clrn64), 64'd1);
    f0 = m_frames[0];
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (140) @(negedge clk);
    #1 chk("post_reset_bits", m_bits[0], 64'hDEAD_BEEF_0BAD_F00D);
    chk("post_reset_rises", 64'(m_rises[0]), 64'd64);
    chk("post_reset_frames", 64'(m_frames[0] - f0), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
